adc_capture_ctrl: RTL and testbench

Triggered capture sequencer that sits downstream of the ADC input capture stage, in the `dclk` domain. It turns the free-running 16-bit offset-binary-corrected I/Q sample stream into bounded, trigger-aligned records. Each record is `cfg_len` samples, taken `cfg_delay` cycles after a trigger. Records are buffered in a small FIFO and presented as a valid/ready stream to the SRIO packetiser, with overflow detection and abort.

---
 rtl/adc_capture_pkg.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 75 +++++++
 rtl/adc_capture_ctrl.sv | 161 ++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC capture sequencer.
package adc_capture_pkg;

    localparam int DW_DFLT      = 16;
    localparam int LEN_W_DFLT   = 16;
    localparam int FIFO_AW_DFLT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_DRAIN
    } cap_state_e;

    // FIFO word layout: {last, I, Q}
    function automatic logic [2*DW_DFLT:0] pack_word(
        input logic                last,
        input logic [DW_DFLT-1:0]  i_smp,
        input logic [DW_DFLT-1:0]  q_smp
    );
        return {last, i_smp, q_smp};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with flush and an
// overwrite-newest port used to place a record's last word when full.
module sync_fifo_fwft #(
    parameter int W  = 33,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_en,
    input  logic         ow_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        pop      = rd_en && !empty;
        // a read in the same cycle frees the slot, so a full FIFO still accepts
        push     = wr_en && (!full || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
            end else if (ow_en && !empty) begin
                mem_q[wr_ptr_q - 1'b1] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Trigger-aligned record capture from the I/Q sample stream into a FWFT
// FIFO, presented downstream as a valid/ready stream.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for arm
// ST_ARMED   | config latched, waiting for trig
// ST_DELAY   | counting trigger-to-first-sample delay
// ST_CAPTURE | writing one sample per cycle into the FIFO
// ST_DRAIN   | waiting for the last-flagged word to handshake
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DW      = DW_DFLT,
    parameter int LEN_W   = LEN_W_DFLT,
    parameter int FIFO_AW = FIFO_AW_DFLT
) (
    input  logic            dclk,
    input  logic            reset,
    input  logic [DW-1:0]   din_i,
    input  logic [DW-1:0]   din_q,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [LEN_W-1:0] cfg_delay,
    input  logic            arm,
    input  logic            trig,
    input  logic            abort,
    output logic [2*DW-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    cap_state_e     state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] delay_q, delay_d;
    logic [LEN_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;

    logic           fifo_flush, fifo_wr, fifo_ow;
    logic           fifo_full, fifo_empty;
    logic [2*DW:0]  fifo_rd_data;
    logic           rd_fire, last_fire, sample_last;

    sync_fifo_fwft #(
        .W  (2*DW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (dclk),
        .rst     (reset),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .ow_en   (fifo_ow),
        .wr_data (pack_word(sample_last, din_i, din_q)),
        .rd_en   (dout_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        delay_d     = delay_q;
        dly_cnt_d   = dly_cnt_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        fifo_flush  = 1'b0;
        fifo_wr     = 1'b0;
        fifo_ow     = 1'b0;
        rd_fire     = !fifo_empty && dout_ready;
        last_fire   = rd_fire && fifo_rd_data[2*DW];
        sample_last = (rem_q == LEN_W'(1));

        if (abort) begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d    = ST_ARMED;
                        len_d      = cfg_len;
                        delay_d    = cfg_delay;
                        ovf_d      = 1'b0;
                        fifo_flush = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        rem_d     = len_q;
                        dly_cnt_d = delay_q;
                        if (len_q == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (delay_q != '0) begin
                            state_d = ST_DELAY;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_DELAY: begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                    if (dly_cnt_q == LEN_W'(1)) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    fifo_wr = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (fifo_full && !rd_fire) begin
                        ovf_d   = 1'b1;
                        // dropped last sample replaces the newest unread word
                        fifo_ow = sample_last;
                    end
                    if (sample_last) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (last_fire) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            delay_q   <= '0;
            dly_cnt_q <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            delay_q   <= delay_d;
            dly_cnt_q <= dly_cnt_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage is not reset, so the data path is forced to zero while empty
    assign dout_valid = !fifo_empty;
    assign dout_last  = !fifo_empty && fifo_rd_data[2*DW];
    assign dout       = fifo_empty ? '0 : fifo_rd_data[2*DW-1:0];
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomised and directed stimulus for adc_capture_ctrl against a
// record/time-window reference model with a 16-entry queue.
module tb_adc_capture_ctrl;

    logic        dclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] din_i = '0, din_q = '0;
    logic [15:0] cfg_len = '0, cfg_delay = '0;
    logic        arm = 1'b0, trig = 1'b0, abort = 1'b0, dout_ready = 1'b0;
    logic [31:0] dout;
    logic        dout_valid, dout_last, busy, done, overflow;

    always #5 dclk = ~dclk;

    adc_capture_ctrl dut (
        .dclk       (dclk),
        .reset      (reset),
        .din_i      (din_i),
        .din_q      (din_q),
        .cfg_len    (cfg_len),
        .cfg_delay  (cfg_delay),
        .arm        (arm),
        .trig       (trig),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: record described by its write window in absolute cycles
    logic [32:0] m_q[$];
    bit          m_busy = 0, m_armed = 0, m_done = 0, m_ovf = 0;
    int          m_len = 0, m_dly = 0, m_wstart = 0;
    int          cyc = 0;
    bit          use_ramp = 1;
    int          n_words = 0, n_last = 0, done_cyc = -1;

    task automatic model_reset();
        m_q.delete();
        m_busy  = 0;
        m_armed = 0;
        m_done  = 0;
        m_ovf   = 0;
    endtask

    task automatic tick(input bit a, input bit t, input bit ab, input bit rdy,
                        input int len, input int dly);
        logic [15:0] di, dq;
        logic [32:0] w;
        bit          fire, popped_last;
        int          k;
        @(negedge dclk);
        chk("dout_valid", dout_valid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("dout", dout, m_q[0][31:0]);
            chk("dout_last", dout_last, m_q[0][32]);
        end
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        if (dout_valid && rdy) begin
            n_words++;
            if (dout_last) n_last++;
        end
        if (done) done_cyc = cyc;

        di = use_ramp ? 16'(cyc) : 16'($urandom);
        dq = use_ramp ? ~16'(cyc) : 16'($urandom);
        din_i      = di;
        din_q      = dq;
        arm        = a;
        trig       = t;
        abort      = ab;
        dout_ready = rdy;
        cfg_len    = 16'(len);
        cfg_delay  = 16'(dly);

        fire        = (m_q.size() != 0) && rdy;
        popped_last = 0;
        m_done      = 0;
        if (ab) begin
            m_q.delete();
            m_busy  = 0;
            m_armed = 0;
        end else if (!m_busy) begin
            if (a) begin
                m_busy  = 1;
                m_armed = 1;
                m_len   = len;
                m_dly   = dly;
                m_ovf   = 0;
                m_q.delete();
            end
        end else if (m_armed) begin
            if (t) begin
                m_armed = 0;
                if (m_len == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_wstart = cyc + 1 + m_dly;
                end
            end
        end else begin
            if (fire) begin
                popped_last = m_q[0][32];
                void'(m_q.pop_front());
            end
            if (cyc >= m_wstart && cyc < m_wstart + m_len) begin
                k = cyc - m_wstart;
                w = {k == m_len - 1, di, dq};
                if (m_q.size() < 16) begin
                    m_q.push_back(w);
                end else begin
                    m_ovf = 1;
                    if (w[32]) m_q[m_q.size()-1] = w;
                end
            end
            if (popped_last) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) tick(0, 0, 0, rdy, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit rdy_r;

        repeat (3) @(negedge dclk);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // basic record
        n_words = 0; n_last = 0; done_cyc = -1;
        tick(1, 0, 0, 1, 8, 0);
        t0 = cyc;
        tick(0, 1, 0, 1, 0, 0);
        idle(12, 1);
        chk("basic_done_cyc", done_cyc - t0, 10);
        chk("basic_words", n_words, 8);
        chk("basic_lasts", n_last, 1);

        // delayed record
        n_words = 0; done_cyc = -1;
        tick(1, 0, 0, 1, 3, 5);
        t0 = cyc;
        tick(0, 1, 0, 1, 0, 0);
        idle(14, 1);
        chk("delay_done_cyc", done_cyc - t0, 10);
        chk("delay_words", n_words, 3);

        // overflow with late ready: 16 buffered + 11 written after ready rises
        n_words = 0; n_last = 0; done_cyc = -1;
        tick(1, 0, 0, 0, 40, 0);
        tick(0, 1, 0, 0, 0, 0);
        idle(29, 0);
        for (int i = 0; i < 80 && done_cyc < 0; i++) tick(0, 0, 0, 1, 0, 0);
        chk("ovf40_done_seen", done_cyc >= 0, 1);
        chk("ovf40_words", n_words, 27);
        chk("ovf40_lasts", n_last, 1);
        chk("ovf40_sticky", overflow, 1);

        // dropped last sample lands on the newest buffered word
        n_words = 0; n_last = 0; done_cyc = -1;
        tick(1, 0, 0, 0, 20, 0);
        tick(0, 1, 0, 0, 0, 0);
        idle(25, 0);
        for (int i = 0; i < 40 && done_cyc < 0; i++) tick(0, 0, 0, 1, 0, 0);
        chk("ovf20_done_seen", done_cyc >= 0, 1);
        chk("ovf20_words", n_words, 16);
        chk("ovf20_lasts", n_last, 1);

        // abort in DELAY, then mid-CAPTURE colliding with arm/trig, then a clean record
        done_cyc = -1;
        tick(1, 0, 0, 1, 5, 6);
        tick(0, 1, 0, 1, 0, 0);
        idle(2, 1);
        tick(0, 0, 1, 1, 0, 0);
        idle(3, 1);
        tick(1, 0, 0, 0, 10, 0);
        tick(0, 1, 0, 0, 0, 0);
        idle(4, 0);
        tick(1, 1, 1, 1, 7, 0);
        idle(3, 1);
        chk("abort_no_done", done_cyc, -1);
        n_words = 0;
        tick(1, 0, 0, 1, 6, 2);
        tick(0, 1, 0, 1, 0, 0);
        idle(12, 1);
        chk("post_abort_words", n_words, 6);

        // zero length, trig in IDLE, trig with arm, arm during CAPTURE
        done_cyc = -1;
        tick(0, 1, 0, 1, 0, 0);
        tick(1, 1, 0, 1, 0, 3);
        t0 = cyc;
        tick(0, 1, 0, 1, 0, 0);
        idle(3, 1);
        chk("zero_len_done_cyc", done_cyc - t0, 1);
        n_words = 0;
        tick(1, 0, 0, 1, 5, 0);
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(1, 1, 0, 1, 30, 0);
        idle(10, 1);
        chk("arm_in_capture_words", n_words, 5);

        // asynchronous reset in DRAIN with overflow set
        tick(1, 0, 0, 0, 20, 0);
        tick(0, 1, 0, 0, 0, 0);
        idle(22, 0);
        @(negedge dclk);
        chk("pre_rst_valid", dout_valid, 1);
        chk("pre_rst_overflow", overflow, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_dout_last", dout_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_overflow", overflow, 0);
        model_reset();
        @(negedge dclk);
        reset = 1'b0;

        // randomised traffic
        use_ramp = 0;
        rdy_r    = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 8) rdy_r = ~rdy_r;
            tick($urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 199) < 2,
                 rdy_r,
                 ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 24)),
                 $urandom_range(0, 6));
        end
        idle(60, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
